// File: rtl/fb_writer.sv
// Pixel-stream to double-buffered framebuffer writer.
// Fills the bank the display is not reading and swaps banks on frame sync once a full frame is stored.
module fb_writer #(
  parameter int unsigned WIDTH     = 320,
  parameter int unsigned HEIGHT    = 240,
  parameter int unsigned ADDR_BITS = 18
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [3:0]           pixel_in,
  input  logic                 pixel_valid_in,
  input  logic                 sof_in,
  output logic                 pixel_ready_out,
  input  logic                 frame_sync_in,
  output logic [ADDR_BITS-1:0] write_addr_out,
  output logic [3:0]           write_data_out,
  output logic                 write_en_out,
  output logic                 read_bank_out,
  output logic [7:0]           frame_count_out,
  output logic                 sof_err_out
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0]        X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]        Y_LAST = YW'(HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] FRAME  = ADDR_BITS'(WIDTH * HEIGHT);

  typedef enum logic {WRITING, WAIT_SWAP} state_t;

  state_t                 state, state_nx;
  logic [XW-1:0]          x, x_nx, x_cur;
  logic [YW-1:0]          y, y_nx, y_cur;
  logic [ADDR_BITS-1:0]   offset, offset_nx, off_cur, waddr;
  logic                   read_bank_nx, sof_err_nx;
  logic [7:0]             frame_count_nx;
  logic                   accept, resync, last, swap;

  always_comb begin
    state_nx       = state;
    x_nx           = x;
    y_nx           = y;
    offset_nx      = offset;
    read_bank_nx   = read_bank_out;
    frame_count_nx = frame_count_out;
    sof_err_nx     = sof_err_out;
    swap           = 1'b0;

    accept  = pixel_valid_in & pixel_ready_out;
    // A mid-frame sof restarts the frame at this very pixel, so the write uses offset 0.
    resync  = accept & sof_in & (offset != '0);
    x_cur   = resync ? '0 : x;
    y_cur   = resync ? '0 : y;
    off_cur = resync ? '0 : offset;
    last    = accept && (x_cur == X_LAST) && (y_cur == Y_LAST);
    waddr   = (read_bank_out ? '0 : FRAME) + off_cur;

    case (state)
      WRITING: begin
        if (accept) begin
          sof_err_nx = sof_err_out | resync;
          offset_nx  = off_cur + ADDR_BITS'(1);
          if (x_cur == X_LAST) begin
            x_nx = '0;
            y_nx = y_cur + YW'(1);
          end else begin
            x_nx = x_cur + XW'(1);
            y_nx = y_cur;
          end
          if (last) begin
            if (frame_sync_in) swap = 1'b1;
            else               state_nx = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (frame_sync_in) begin
          swap     = 1'b1;
          state_nx = WRITING;
        end
      end
      default: state_nx = WRITING;
    endcase

    if (swap) begin
      read_bank_nx   = ~read_bank_out;
      frame_count_nx = frame_count_out + 8'd1;
      x_nx           = '0;
      y_nx           = '0;
      offset_nx      = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state           <= WRITING;
      x               <= '0;
      y               <= '0;
      offset          <= '0;
      pixel_ready_out <= 1'b0;
      write_en_out    <= 1'b0;
      write_addr_out  <= '0;
      write_data_out  <= '0;
      read_bank_out   <= 1'b0;
      frame_count_out <= '0;
      sof_err_out     <= 1'b0;
    end else begin
      state           <= state_nx;
      x               <= x_nx;
      y               <= y_nx;
      offset          <= offset_nx;
      pixel_ready_out <= (state_nx == WRITING);
      write_en_out    <= accept;
      read_bank_out   <= read_bank_nx;
      frame_count_out <= frame_count_nx;
      sof_err_out     <= sof_err_nx;
      if (accept) begin
        write_addr_out <= waddr;
        write_data_out <= pixel_in;
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed-plus-random bench for fb_writer against a frame-level reference model.
module tb_fb_writer;

  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pix;
  logic       valid, sof, fsync;
  logic       ready, we, bank, err;
  logic [3:0] waddr, wdata;
  logic [7:0] fcount;

  int checks = 0;
  int errors = 0;

  // Reference model state: bank read by display, frames swapped, pixel index in frame.
  int m_bank, m_count, m_idx, m_full, m_err, m_ready;
  int e_we, e_addr, e_data;

  fb_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_BITS(4)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .pixel_in        (pix),
    .pixel_valid_in  (valid),
    .sof_in          (sof),
    .pixel_ready_out (ready),
    .frame_sync_in   (fsync),
    .write_addr_out  (waddr),
    .write_data_out  (wdata),
    .write_en_out    (we),
    .read_bank_out   (bank),
    .frame_count_out (fcount),
    .sof_err_out     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit s, input bit fs, input logic [3:0] p);
    bit acc;
    rst_n = !rst;
    valid = v;
    sof   = s;
    fsync = fs;
    pix   = p;
    if (rst) begin
      m_bank = 0; m_count = 0; m_idx = 0; m_full = 0; m_err = 0; m_ready = 0;
      e_we = 0; e_addr = 0; e_data = 0;
    end else begin
      acc  = v && (m_ready != 0);
      e_we = acc ? 1 : 0;
      if (acc) begin
        if (s && m_idx != 0) begin
          m_idx = 0;
          m_err = 1;
        end
        e_addr = (m_bank != 0 ? 0 : FRAME) + m_idx;
        e_data = int'(p);
        m_idx++;
        if (m_idx == FRAME) m_full = 1;
      end
      if (fs && m_full != 0) begin
        m_bank  = 1 - m_bank;
        m_count = (m_count + 1) % 256;
        m_idx   = 0;
        m_full  = 0;
      end
      m_ready = (m_full == 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("write_en", 32'(we), 32'(e_we));
    if (e_we != 0 || rst) begin
      chk("write_addr", 32'(waddr), 32'(e_addr));
      chk("write_data", 32'(wdata), 32'(e_data));
    end
    chk("ready", 32'(ready), 32'(m_ready));
    chk("read_bank", 32'(bank), 32'(m_bank));
    chk("frame_count", 32'(fcount), 32'(m_count));
    chk("sof_err", 32'(err), 32'(m_err));
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0; fsync = 1'b0; pix = '0;

    step(1, 0, 0, 0, 4'h0);
    step(1, 1, 1, 1, 4'hF);
    step(0, 0, 0, 0, 4'h0);

    // First frame 0..7 into bank 1, then stall with valid held high.
    for (int i = 0; i < 8; i++) step(0, 1, i == 0, 0, 4'(i));
    step(0, 1, 0, 0, 4'hA);
    step(0, 1, 0, 0, 4'hB);
    step(0, 0, 0, 1, 4'h0);

    // Mid-frame sync is ignored.
    for (int i = 0; i < 3; i++) step(0, 1, i == 0, 0, 4'($urandom));
    step(0, 0, 0, 1, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'($urandom));
    // Last pixel coincident with sync.
    step(0, 1, 0, 1, 4'($urandom));

    // Resync on the 4th pixel, then 7 more accepts complete the frame.
    for (int i = 0; i < 3; i++) step(0, 1, i == 0, 0, 4'($urandom));
    step(0, 1, 1, 0, 4'($urandom));
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 4'($urandom));
    step(0, 1, 0, 0, 4'($urandom));
    step(0, 0, 0, 1, 4'h0);

    // Gapped valid then a one-cycle reset mid-frame.
    for (int i = 0; i < 6; i++) step(0, i % 2 == 0, i == 0, 0, 4'($urandom));
    step(1, 1, 0, 0, 4'($urandom));
    step(0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 8; i++) step(0, 1, i == 0, 0, 4'($urandom));
    step(0, 0, 0, 1, 4'h0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
